// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port RAM with registered read port for the fifo
module fifo_mem #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    // Write port: store the word at the write address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered output that holds its value when no read is enabled.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo.sv
// rtl/fifo.sv - single-clock fifo with fill level and threshold flags
module fifo #(
    parameter int DWIDTH       = 16,
    parameter int AWIDTH       = 8,
    parameter int ALMOST_FULL  = 2,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              wrreq_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              almost_empty_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              full_o,
    output logic [AWIDTH:0]   usedw_o
);

    localparam logic [AWIDTH:0]   DEPTH   = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0]   CNT_ONE = (AWIDTH+1)'(1);
    localparam logic [AWIDTH:0]   CNT_NIL = '0;
    localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);
    localparam logic [AWIDTH:0]   AF_LVL  = (AWIDTH+1)'(ALMOST_FULL);
    localparam logic [AWIDTH:0]   AE_LVL  = (AWIDTH+1)'(ALMOST_EMPTY);

    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   usedw_q;
    logic [AWIDTH:0]   usedw_next;
    logic              empty_q;
    logic              full_q;
    logic              almost_empty_q;
    logic              almost_full_q;
    logic              q_clear;
    logic              wr_en;
    logic              rd_en;
    logic [DWIDTH-1:0] rd_data;

    // Acceptance uses the registered flags, so a full fifo drops writes and an
    // empty one ignores reads; reset blocks both so the RAM read register holds.
    assign wr_en = wrreq_i && !full_q  && !srst_i;
    assign rd_en = rdreq_i && !empty_q && !srst_i;

    // Next fill level: only a one-sided accept changes the count.
    always_comb begin
        usedw_next = usedw_q;
        case ({wr_en, rd_en})
            2'b10:   usedw_next = usedw_q + CNT_ONE;
            2'b01:   usedw_next = usedw_q - CNT_ONE;
            default: usedw_next = usedw_q;
        endcase
    end

    // Pointers, fill level and flags; flags follow the next fill level so they
    // always agree with usedw_o.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            usedw_q        <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= (CNT_NIL < AE_LVL);
            almost_full_q  <= (CNT_NIL >= AF_LVL);
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            usedw_q        <= usedw_next;
            empty_q        <= (usedw_next == CNT_NIL);
            full_q         <= (usedw_next == DEPTH);
            almost_empty_q <= (usedw_next < AE_LVL);
            almost_full_q  <= (usedw_next >= AF_LVL);
        end
    end

    // The RAM is never cleared, so q_o is masked to zero from reset until the
    // first accepted read loads fresh data into the read register.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            q_clear <= 1'b1;
        end else if (rd_en) begin
            q_clear <= 1'b0;
        end
    end

    fifo_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk     (clk_i),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (data_i),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign q_o            = q_clear ? '0 : rd_data;
    assign usedw_o        = usedw_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign almost_empty_o = almost_empty_q;
    assign almost_full_o  = almost_full_q;

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
Synchronous single-clock first-in/first-out buffer. It has the same port set and flag semantics as the team's lifo block and is a drop-in alternative wherever ordering must be preserved. Storage is 2**AWIDTH words in an inferred simple dual-port RAM. Read data is registered: q_o is valid one clock after an accepted read (normal mode, no show-ahead).

Parameters:
DWIDTH, 16, data word width in bits
AWIDTH, 8, address width; depth = 2**AWIDTH words
ALMOST_FULL, 2, almost_full_o asserts when usedw_o >= ALMOST_FULL
ALMOST_EMPTY, 2, almost_empty_o asserts when usedw_o < ALMOST_EMPTY

Ports:
clk_i  input  1  clock; all logic on rising edge
srst_i  input  1  reset, synchronous, active-high
wrreq_i  input  1  write request
data_i  input  DWIDTH  write data, sampled with wrreq_i
rdreq_i  input  1  read request
q_o  output  DWIDTH  read data, registered
almost_empty_o  output  1  usedw_o < ALMOST_EMPTY
empty_o  output  1  usedw_o == 0
almost_full_o  output  1  usedw_o >= ALMOST_FULL
full_o  output  1  usedw_o == 2**AWIDTH
usedw_o  output  AWIDTH+1  number of stored words, 0..2**AWIDTH

Behaviour:
- Reset: one clock, synchronous, active-high (srst_i). On the reset edge:
  - wr_ptr, rd_ptr and usedw_o go to 0.
  - empty_o=1, almost_empty_o=1 (ALMOST_EMPTY>0), full_o=0, q_o=0.
  - almost_full_o=1 only if ALMOST_FULL==0, else 0.
  - RAM contents are not cleared.
  - Reset has priority over wrreq_i and rdreq_i in the same cycle. Reset mid-stream discards all stored data.
- Accepted write: wrreq_i && !full_o. data_i is written at mem[wr_ptr]; wr_ptr increments modulo 2**AWIDTH.
- Accepted read: rdreq_i && !empty_o. q_o <= mem[rd_ptr] on that edge, so data is visible in the cycle after the request. rd_ptr increments modulo 2**AWIDTH.
- Rejected write (when full) is ignored silently. Rejected read (when empty) is ignored, and q_o holds its previous value.
- Simultaneous requests:
  - Empty: only the write is accepted; usedw_o becomes 1.
  - Full: only the read is accepted; usedw_o becomes 2**AWIDTH-1.
  - Otherwise: both are accepted and usedw_o is unchanged.
  - Read and write never target the same address in one cycle, because the read is accepted only when non-empty.
- usedw_o: +1 on a write-only accept, -1 on a read-only accept. It is held in an AWIDTH+1-bit register and never exceeds 2**AWIDTH or goes below 0.
- Flags are registered and derived from the next value of usedw_o, so they are consistent with usedw_o in every cycle.
- Pointers are AWIDTH bits and wrap naturally. usedw_o alone distinguishes full from empty.
- Write-to-read latency: a word written at edge N can be requested in the cycle after N; its data appears on q_o after edge N+1.

Decomposition:
- No shared package: all widths derive from module parameters.
- One sub-module: fifo_mem, a simple dual-port RAM.
  - Ports: clk, wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_data (registered).
  - fifo_mem contains no reset logic.
- The fifo top holds pointers, usedw and flags. q_o is fifo_mem's rd_data, zeroed by a reset-clear flop. The flop is set on reset and cleared on the first accepted read.

Test Plan:
- Fill then drain: reset, then 257 writes with random data (the last is rejected). Require full_o=1 and usedw_o=256. Then 257 reads: the first 256 q_o values equal the write order; the last read is rejected; empty_o=1 and usedw_o=0.
- Read from empty: after reset, hold rdreq_i for 3 cycles. Require usedw_o=0, empty_o=1, q_o=0 throughout.
- Flag thresholds: write 1, 2, 3 words. almost_empty_o must read 1 at usedw 1 and 0 at usedw 2. Fill to 254 and 255: almost_full_o=1 already from usedw 2, full_o=0 until 256.
- Simultaneous read/write:
  - At usedw=5, 20 cycles with both requests: usedw_o stays 5 and the data order is preserved.
  - At empty: usedw_o goes to 1.
  - At full: usedw_o goes to 255, and the write data is dropped.
- Wrap-around: repeat 3x (write 200, read 200). Require pointers wrap and every q_o matches the reference queue in order.
- Reset mid-operation: write 10, read 3, assert srst_i together with wrreq_i. Next cycle require usedw_o=0, empty_o=1, q_o=0. A subsequent write/read returns the new data.
